// File: rtl/bsg_manycore_loader_arbiter.sv
// -----------------------------------------------------------------------------
// bsg_manycore_loader_arbiter
//
// Shares one credit-flow-controlled loader link between num_req_p host-side
// requesters. A round-robin arbiter picks one valid requester per cycle and
// loads its packet into a single output register (pkt_o / pkt_v_o). Every
// grant consumes one credit; every credit_return_i restores one. A fence
// request stops new grants until the link has drained completely.
//
// Handshakes:
//   req side  : req_yumi_o[i] is a same-cycle dequeue of req_packet_i[i]; it is
//               only raised while req_v_i[i]=1 and is one-hot.
//   link side : pkt_o transfers on a cycle where pkt_v_o & pkt_ready_i; pkt_o and
//               grant_id_o hold steady while pkt_v_o=1 and pkt_ready_i=0.
//
// Parameters:
//   num_req_p          number of requesters (2..16)
//   packet_width_p     packet width in bits; no meaningful default, always set it
//   max_out_credits_p  outstanding request limit on the link (1..255)
//
// Ports:
//   clk_i              clock
//   reset_n_i          synchronous active-low reset
//   req_v_i            per-requester valid
//   req_packet_i       per-requester packet
//   req_yumi_o         one-hot dequeue in the grant cycle
//   pkt_v_o, pkt_o     registered packet toward the link
//   pkt_ready_i        link accepts pkt_o
//   credit_return_i    one credit restored
//   fence_i            single-cycle fence request
//   fence_done_o       single-cycle fence completion pulse
//   grant_id_o         requester index of the packet in pkt_o
//   out_credits_o      current credit count
//   credit_err_o       sticky flag: credit returned while already at maximum
//   fsm_state_o        debug view of the FSM: 0 = RUN, 1 = FENCE
//   stall_cycles_o     (only with BSG_MANYCORE_LOADER_ARB_STATS_EN) saturating
//                      count of cycles with some req_v_i set and no grant
//
// Optional feature macro: BSG_MANYCORE_LOADER_ARB_STATS_EN
// -----------------------------------------------------------------------------
module bsg_manycore_loader_arbiter #(
    parameter int num_req_p         = 4,
    parameter int packet_width_p    = 32,
    parameter int max_out_credits_p = 16,
    localparam int id_width_lp      = $clog2(num_req_p),
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,

    input  logic [num_req_p-1:0]                     req_v_i,
    input  logic [num_req_p-1:0][packet_width_p-1:0] req_packet_i,
    output logic [num_req_p-1:0]                     req_yumi_o,

    output logic                                     pkt_v_o,
    output logic [packet_width_p-1:0]                pkt_o,
    input  logic                                     pkt_ready_i,

    input  logic                                     credit_return_i,

    input  logic                                     fence_i,
    output logic                                     fence_done_o,

    output logic [id_width_lp-1:0]                   grant_id_o,
    output logic [credit_width_lp-1:0]               out_credits_o,
    output logic                                     credit_err_o,
    output logic                                     fsm_state_o
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
    ,
    output logic [31:0]                              stall_cycles_o
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FENCE = 1'b1
    } state_e;

    // One extra bit so last_grant + 1 + offset never overflows before wrapping.
    localparam int sum_w_lp = id_width_lp + 1;

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);
    localparam logic [id_width_lp-1:0]     last_id_lp     = id_width_lp'(num_req_p - 1);
    localparam logic [sum_w_lp-1:0]        num_req_lp     = sum_w_lp'(num_req_p);

    state_e                     state_r;
    logic [id_width_lp-1:0]     last_grant_r;
    logic [credit_width_lp-1:0] credits_r;

    logic                       loadable;
    logic                       grant;
    logic                       grant_found;
    logic [id_width_lp-1:0]     grant_sel;
    logic                       fence_ready;
    logic [sum_w_lp-1:0]        rr_sum;
    logic [id_width_lp-1:0]     rr_idx;

    // -------------------------------------------------------------------------
    // Round-robin pick: scan from last_grant+1 upward, wrapping at num_req_p.
    // The sum is at most 2*num_req_p-1, so one conditional subtract wraps it.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = '0;
        rr_sum      = '0;
        rr_idx      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            rr_sum = {1'b0, last_grant_r} + sum_w_lp'(i) + sum_w_lp'(1);
            if (rr_sum >= num_req_lp) begin
                rr_sum = rr_sum - num_req_lp;
            end
            rr_idx = rr_sum[id_width_lp-1:0];
            if (!grant_found && req_v_i[rr_idx]) begin
                grant_found = 1'b1;
                grant_sel   = rr_idx;
            end
        end
    end

    // The output register can take a new packet when it is empty or its
    // current packet leaves this cycle.
    assign loadable = !pkt_v_o || pkt_ready_i;

    // A grant needs RUN state; fence_i blocks the grant in its own cycle, and
    // the FENCE->RUN cycle still reads FENCE so it never grants either.
    assign grant = reset_n_i
                && loadable
                && (credits_r != '0)
                && (state_r == ST_RUN)
                && !fence_i
                && grant_found;

    always_comb begin
        req_yumi_o = '0;
        if (grant) begin
            req_yumi_o[grant_sel] = 1'b1;
        end
    end

    // The fence completes once nothing is held locally and every credit is back.
    assign fence_ready  = (state_r == ST_FENCE) && !pkt_v_o && (credits_r == max_credits_lp);
    assign fence_done_o = reset_n_i && fence_ready;

    assign out_credits_o = credits_r;
    assign fsm_state_o   = (state_r == ST_FENCE);

    // -------------------------------------------------------------------------
    // FSM, output register, round-robin pointer and credit counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r      <= ST_RUN;
            pkt_v_o      <= 1'b0;
            pkt_o        <= '0;
            grant_id_o   <= '0;
            last_grant_r <= last_id_lp;
            credits_r    <= max_credits_lp;
            credit_err_o <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (fence_i) begin
                        state_r <= ST_FENCE;
                    end
                end
                ST_FENCE: begin
                    // fence_i is deliberately not looked at here.
                    if (fence_ready) begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase

            if (grant) begin
                pkt_v_o      <= 1'b1;
                pkt_o        <= req_packet_i[grant_sel];
                grant_id_o   <= grant_sel;
                last_grant_r <= grant_sel;
            end else if (pkt_v_o && pkt_ready_i) begin
                pkt_v_o <= 1'b0;
            end

            // A grant and a return in the same cycle cancel out, even at the
            // maximum, so only a lone return at the maximum is an overflow.
            if (grant && !credit_return_i) begin
                credits_r <= credits_r - credit_width_lp'(1);
            end else if (!grant && credit_return_i) begin
                if (credits_r == max_credits_lp) begin
                    credit_err_o <= 1'b1;
                end else begin
                    credits_r <= credits_r + credit_width_lp'(1);
                end
            end
        end
    end

`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
    // Cycles where someone wanted the link and nobody got it; sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            stall_cycles_o <= '0;
        end else if ((|req_v_i) && !grant && (stall_cycles_o != '1)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_loader_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bsg_manycore_loader_arbiter
//
// Main instance: 4 requesters, 16-bit packets, 5 credits.
// Second instance: 3 requesters, 2 credits, for credit exhaustion and a
// non-power-of-two round-robin wrap.
// -----------------------------------------------------------------------------
module tb_bsg_manycore_loader_arbiter;

    localparam int NUM  = 4;
    localparam int W    = 16;
    localparam int MAX  = 5;
    localparam int NUM2 = 3;
    localparam int MAX2 = 2;
    localparam int NV   = 19;
    localparam int NRAND = 3000;

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic [NUM-1:0]        req_v;
    logic [NUM-1:0][W-1:0] req_packet;
    logic [NUM-1:0]        yumi;
    logic                  pkt_v;
    logic [W-1:0]          pkt;
    logic                  pkt_ready;
    logic                  credit_return;
    logic                  fence;
    logic                  fence_done;
    logic [1:0]            gid;
    logic [2:0]            cred;
    logic                  err;
    logic                  state_dbg;

    logic [NUM2-1:0]       c2_yumi;
    logic                  c2_pkt_v;
    logic [W-1:0]          c2_pkt;
    logic                  c2_fence_done;
    logic [1:0]            c2_gid;
    logic [1:0]            c2_cred;
    logic                  c2_err;
    logic                  c2_state;
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
    logic [31:0]           stall;
    logic [31:0]           c2_stall;
`endif

    bsg_manycore_loader_arbiter #(
        .num_req_p        (NUM),
        .packet_width_p   (W),
        .max_out_credits_p(MAX)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_v_i        (req_v),
        .req_packet_i   (req_packet),
        .req_yumi_o     (yumi),
        .pkt_v_o        (pkt_v),
        .pkt_o          (pkt),
        .pkt_ready_i    (pkt_ready),
        .credit_return_i(credit_return),
        .fence_i        (fence),
        .fence_done_o   (fence_done),
        .grant_id_o     (gid),
        .out_credits_o  (cred),
        .credit_err_o   (err),
        .fsm_state_o    (state_dbg)
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
        ,
        .stall_cycles_o (stall)
`endif
    );

    bsg_manycore_loader_arbiter #(
        .num_req_p        (NUM2),
        .packet_width_p   (W),
        .max_out_credits_p(MAX2)
    ) dut_c2 (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_v_i        (req_v[NUM2-1:0]),
        .req_packet_i   (req_packet[NUM2-1:0]),
        .req_yumi_o     (c2_yumi),
        .pkt_v_o        (c2_pkt_v),
        .pkt_o          (c2_pkt),
        .pkt_ready_i    (pkt_ready),
        .credit_return_i(credit_return),
        .fence_i        (fence),
        .fence_done_o   (c2_fence_done),
        .grant_id_o     (c2_gid),
        .out_credits_o  (c2_cred),
        .credit_err_o   (c2_err),
        .fsm_state_o    (c2_state)
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
        ,
        .stall_cycles_o (c2_stall)
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    int checks = 0;
    int errors = 0;

    // Content of the output register: empty queue means nothing held.
    logic [W-1:0] exp_q[$];
    int           m_out;     // requests granted but not yet credited back
    int           m_last;    // last granted requester
    int           m_id;      // requester of the most recent grant
    bit           m_err;
    bit           m_fence;
    logic [31:0]  m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_out   = 0;
        m_last  = NUM - 1;
        m_id    = 0;
        m_err   = 1'b0;
        m_fence = 1'b0;
        m_stall = '0;
    endfunction

    // Called just after a negedge with inputs already applied. Compares every
    // DUT output against the model, advances the model over the coming
    // posedge, and returns at the next negedge.
    task automatic tick();
        int           sel;
        bit           grant;
        bit           done;
        bit           loadable;
        bit           held;
        logic [NUM-1:0] e_yumi;
        #1;
        held     = (exp_q.size() != 0);
        loadable = !held || pkt_ready;
        sel      = -1;
        for (int k = 1; k <= NUM; k++) begin
            int c = (m_last + k) % NUM;
            if (sel < 0 && req_v[c]) sel = c;
        end
        grant  = reset_n && loadable && (m_out < MAX) && !m_fence && !fence && (sel >= 0);
        done   = reset_n && m_fence && !held && (m_out == 0);
        e_yumi = '0;
        if (grant) e_yumi[sel] = 1'b1;

        chk("yumi",        yumi,       e_yumi);
        chk("pkt_v",       pkt_v,      held);
        chk("credits",     cred,       MAX - m_out);
        chk("credit_err",  err,        m_err);
        chk("fence_done",  fence_done, done);
        chk("state",       state_dbg,  m_fence);
        chk("grant_id",    gid,        m_id);
        if (held) chk("pkt", pkt, exp_q[0]);
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
        chk("stall_cycles", stall, m_stall);
`endif

        if (!reset_n) begin
            model_reset();
        end else begin
            if (held && pkt_ready) void'(exp_q.pop_front());
            if (grant) begin
                exp_q.push_back(req_packet[sel]);
                m_id   = sel;
                m_last = sel;
            end
            if (credit_return && !grant && m_out == 0) begin
                m_err = 1'b1;
            end else begin
                m_out = m_out + int'(grant) - int'(credit_return);
            end
            if (!m_fence) begin
                if (fence) m_fence = 1'b1;
            end else if (done) begin
                m_fence = 1'b0;
            end
            if ((|req_v) && !grant && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic set_in(input logic [NUM-1:0] rv, input logic rdy, input logic ret, input logic fen);
        req_v         = rv;
        pkt_ready     = rdy;
        credit_return = ret;
        fence         = fen;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_in('0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic fixed_packets();
        for (int i = 0; i < NUM; i++) req_packet[i] = W'(16'hA0A0 + i);
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic [NUM-1:0] rv;
        logic           rdy;
        logic           ret;
        logic           fen;
        logic [NUM-1:0] yumi;
        logic           pkt_v;
        logic [1:0]     id;
        logic [2:0]     cred;
        logic           err;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        //            rv       rdy   ret   fen    yumi     pv    id    cred  err
        vecs[0]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 3'd5, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0, 3'd4, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 3'd3, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd2, 3'd3, 1'b0};
        vecs[4]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 3'd2, 1'b0};
        vecs[5]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd3, 3'd2, 1'b0};
        vecs[6]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd0, 3'd1, 1'b0};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 3'd0, 1'b0};
        vecs[8]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 3'd0, 1'b0};
        vecs[9]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd2, 3'd1, 1'b0};
        vecs[10] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 3'd0, 1'b0};
        vecs[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 3'd1, 1'b0};
        vecs[12] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 3'd2, 1'b0};
        vecs[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 3'd3, 1'b0};
        vecs[14] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 3'd4, 1'b0};
        vecs[15] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 3'd5, 1'b0};
        vecs[16] = '{4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd3, 3'd5, 1'b1};
        vecs[17] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 3'd5, 1'b1};
        vecs[18] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 3'd5, 1'b1};
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        reset_n = 1'b0;
        set_in('0, 1'b0, 1'b0, 1'b0);
        fixed_packets();
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;

        // Table: round-robin, backpressure, credit exhaustion, overflow.
        for (int v = 0; v < NV; v++) begin
            set_in(vecs[v].rv, vecs[v].rdy, vecs[v].ret, vecs[v].fen);
            #1;
            chk($sformatf("vec%0d yumi", v),       yumi,  vecs[v].yumi);
            chk($sformatf("vec%0d pkt_v", v),      pkt_v, vecs[v].pkt_v);
            chk($sformatf("vec%0d grant_id", v),   gid,   vecs[v].id);
            chk($sformatf("vec%0d credits", v),    cred,  vecs[v].cred);
            chk($sformatf("vec%0d credit_err", v), err,   vecs[v].err);
            tick();
        end

        // Backpressure: packet held 5 cycles while its source changes.
        do_reset();
        fixed_packets();
        set_in(4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        req_packet[0] = 16'h5555;
        for (int c = 0; c < 5; c++) begin
            set_in(4'b1111, 1'b0, 1'b0, 1'b0);
            #1;
            chk("bp hold pkt", pkt, 16'hA0A0);
            chk("bp hold yumi", yumi, 4'b0000);
            tick();
        end
        set_in(4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        chk("bp release yumi", yumi, 4'b0010);
        tick();

        // Fence with 3 outstanding.
        do_reset();
        fixed_packets();
        for (int c = 0; c < 3; c++) begin
            set_in(4'b0001, 1'b1, 1'b0, 1'b0);
            tick();
        end
        set_in(4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(4'b1111, 1'b1, 1'b0, 1'b1);
        #1;
        chk("fence cycle yumi", yumi, 4'b0000);
        tick();
        for (int c = 0; c < 3; c++) begin
            set_in(4'b1111, 1'b1, 1'b1, (c == 1));
            #1;
            chk("fence wait yumi", yumi, 4'b0000);
            chk("fence wait done", fence_done, 1'b0);
            tick();
        end
        set_in(4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fence done pulse", fence_done, 1'b1);
        chk("fence done yumi", yumi, 4'b0000);
        chk("fence done credits", cred, 3'd5);
        tick();
        #1;
        chk("fence resume yumi", yumi, 4'b0010);
        chk("fence pulse width", fence_done, 1'b0);
        tick();

        // Reset mid-operation with a held packet in FENCE.
        do_reset();
        set_in(4'b0001, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre-reset state", state_dbg, 1'b1);
        chk("pre-reset pkt_v", pkt_v, 1'b1);
        tick();
        reset_n = 1'b0;
        set_in(4'b1111, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset yumi gated", yumi, 4'b0000);
        tick();
        reset_n = 1'b1;
        set_in(4'b1111, 1'b1, 1'b0, 1'b0);
        #1;
        chk("post-reset pkt_v", pkt_v, 1'b0);
        chk("post-reset state", state_dbg, 1'b0);
        chk("post-reset credits", cred, 3'd5);
        chk("post-reset first grant", yumi, 4'b0001);
        tick();

        // Second instance: 3 requesters, 2 credits, no returns then one.
        do_reset();
        begin
            logic [NUM2-1:0] e2_yumi[8];
            logic [1:0]      e2_cred[8];
            e2_yumi = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
            e2_cred = '{2'd2,   2'd1,   2'd0,   2'd0,   2'd0,   2'd1,   2'd0,   2'd0};
            for (int c = 0; c < 8; c++) begin
                set_in(4'b0111, 1'b1, (c == 4), 1'b0);
                #1;
                chk($sformatf("c2 cyc%0d yumi", c), c2_yumi, e2_yumi[c]);
                chk($sformatf("c2 cyc%0d credits", c), c2_cred, e2_cred[c]);
                tick();
            end
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < NRAND; n++) begin
            for (int i = 0; i < NUM; i++) req_packet[i] = W'($urandom);
            req_v         = NUM'($urandom_range(0, 15));
            pkt_ready     = ($urandom_range(0, 9) < 7);
            credit_return = (m_out > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            fence         = ($urandom_range(0, 29) == 0);
            reset_n       = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
